// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// The even-parity helper exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int SAMPLES_PER_BIT = 16;
    localparam int DEF_BR_LIMIT    = 326;
    localparam int DEF_BR_BITS     = 9;
    localparam int DEF_FIFO_EXP    = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    // Narrower payloads are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_core.sv
// Tick-driven 8N1 serialiser FSM (8E1 when UART_TX_PARITY_EN is defined).
// Pops the FIFO head on an IDLE tick and drives a glitch-free registered tx line.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BIT_TICK = 16
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 data_valid,
    input  logic [DATA_BITS-1:0] head_data,
    output logic                 pop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int TICK_MAX = (STOP_BIT_TICK > SAMPLES_PER_BIT) ? STOP_BIT_TICK : SAMPLES_PER_BIT;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(SAMPLES_PER_BIT - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BIT_TICK - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_r, state_s;
    logic [TICK_W-1:0]    tick_cnt_r, tick_cnt_s;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0] shreg_r, shreg_s;
    logic                 tx_r, tx_s;
    logic                 busy_r;
    logic                 done_r, done_s;
    logic                 pop_s;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r, parity_s;
`endif

    // Next-state, datapath and next-tx computation.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shreg_s    = shreg_r;
        done_s     = 1'b0;
        pop_s      = 1'b0;
        tx_s       = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (tick && data_valid) begin
                    pop_s      = 1'b1;
                    shreg_s    = head_data;
                    tick_cnt_s = {TICK_W{1'b0}};
                    bit_cnt_s  = {BIT_W{1'b0}};
                    state_s    = START;
`ifdef UART_TX_PARITY_EN
                    parity_s   = even_parity(32'(head_data));
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        state_s    = DATA;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        shreg_s    = shreg_r >> 1;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_s = {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                            state_s   = PARITY;
`else
                            state_s   = STOP;
`endif
                        end else begin
                            bit_cnt_s = bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        state_s    = STOP;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_r == STOP_LAST) begin
                        tick_cnt_s = {TICK_W{1'b0}};
                        done_s     = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_W'(1);
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // tx follows the state being entered so the line updates on the same edge.
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shreg_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = parity_s;
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State and output registers; reset drops tx high at once.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            tick_cnt_r <= {TICK_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            shreg_r    <= {DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shreg_r    <= shreg_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign pop          = pop_s;
    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = done_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: baud tick divider, 2^FIFO_EXP-entry FWFT byte FIFO and serialiser.
// Define UART_TX_PARITY_EN to send 8E1 frames instead of 8N1.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BIT_TICK = 16,
    parameter int BR_LIMIT      = DEF_BR_LIMIT,
    parameter int BR_BITS       = DEF_BR_BITS,
    parameter int FIFO_EXP      = DEF_FIFO_EXP
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 tx,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int DEPTH = 1 << FIFO_EXP;
    localparam int CNT_W = FIFO_EXP + 1;
    localparam logic [BR_BITS-1:0] BR_LAST   = BR_BITS'(BR_LIMIT - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);

    logic [BR_BITS-1:0]   br_cnt_r;
    logic                 tick_s;
    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [FIFO_EXP-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r, count_s;
    logic                 full_r, empty_r;
    logic                 wr_ok_s, pop_s;
    logic [DATA_BITS-1:0] head_s;

    assign tick_s  = (br_cnt_r == BR_LAST);
    assign wr_ok_s = wr_en & ~full_r;
    assign head_s  = mem_r[rd_ptr_r];

    // Free-running baud divider.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            br_cnt_r <= {BR_BITS{1'b0}};
        end else if (tick_s) begin
            br_cnt_r <= {BR_BITS{1'b0}};
        end else begin
            br_cnt_r <= br_cnt_r + BR_BITS'(1);
        end
    end

    // Occupancy after this cycle's write and pop.
    always_comb begin
        count_s = count_r;
        case ({wr_ok_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {FIFO_EXP{1'b0}};
            rd_ptr_r <= {FIFO_EXP{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_EXP'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_EXP'(1);
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_CNT);
            empty_r <= (count_s == {CNT_W{1'b0}});
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk_50MHz) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    uart_tx_core #(
        .DATA_BITS     (DATA_BITS),
        .STOP_BIT_TICK (STOP_BIT_TICK)
    ) u_core (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .tick         (tick_s),
        .data_valid   (~empty_r),
        .head_data    (head_s),
        .pop          (pop_s),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a shortened baud divider (BR_LIMIT=5).
// Frames are checked sample-by-sample on every falling clock edge.
module tb_uart_tx_fifo;

    localparam int BR  = 5;
    localparam int BIT = 16 * BR;

    logic       clk_50MHz;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx, fifo_full, fifo_empty, tx_busy, tx_done_tick;

    int total, bad, done_cnt;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs [6];

    uart_tx_fifo #(
        .DATA_BITS(8), .STOP_BIT_TICK(16), .BR_LIMIT(BR), .BR_BITS(3), .FIFO_EXP(4)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx           (tx),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) begin
        if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk_50MHz);
        wr_en   = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int n);
        n = 0;
        while (tx !== 1'b0 && n < bound) begin
            @(negedge clk_50MHz);
            n++;
        end
    endtask

    // Called on the first start-bit sample; returns on the sample after the stop bit.
    task automatic recv_frame(input string nm, input logic [9:0] f, input logic p);
        logic [10:0] seq;
        int nb, errs;
`ifdef UART_TX_PARITY_EN
        seq = {f[9], p, f[8:0]};
        nb  = 11;
`else
        seq = {1'b0, f};
        nb  = 10;
`endif
        for (int b = 0; b < nb; b++) begin
            errs = 0;
            for (int s = 0; s < BIT; s++) begin
                if (tx !== seq[b]) errs++;
                @(negedge clk_50MHz);
            end
            check_eq($sformatf("%s bit%0d wrong samples", nm, b), errs, 0);
        end
        check_eq({nm, " done_tick"}, int'(tx_done_tick === 1'b1), 1);
        check_eq({nm, " busy"}, int'(tx_busy === 1'b1), 0);
    endtask

    task automatic check_gap(input string nm);
        int n;
        wait_start(4 * BR, n);
        check_eq({nm, " gap"}, n, BR);
    endtask

    task automatic idle_watch(input string nm, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk_50MHz);
        end
        check_eq({nm, " idle low samples"}, lows, 0);
    endtask

    initial begin
        int n, d0;
        total = 0; bad = 0; done_cnt = 0;
        reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00;

        vecs[0] = '{8'h55, 10'b1010101010, 1'b0};
        vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[2] = '{8'h03, 10'b1000000110, 1'b0};
        vecs[3] = '{8'hA3, 10'b1101000110, 1'b0};
        vecs[4] = '{8'h0F, 10'b1000011110, 1'b0};
        vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};

        repeat (3) @(negedge clk_50MHz);
        check_eq("rst tx", int'(tx === 1'b1), 1);
        check_eq("rst busy", int'(tx_busy === 1'b1), 0);
        check_eq("rst done", int'(tx_done_tick === 1'b1), 0);
        check_eq("rst empty", int'(fifo_empty === 1'b1), 1);
        check_eq("rst full", int'(fifo_full === 1'b1), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_50MHz);

        // Single frames with latency bound
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            push(vecs[i].data);
            wait_start(BR + 2, n);
            check_eq($sformatf("single %0d latency ok", i), int'(n >= 1 && n <= BR), 1);
            recv_frame($sformatf("single %02h", vecs[i].data), vecs[i].frame, vecs[i].par);
            @(negedge clk_50MHz);
            check_eq($sformatf("single %0d done count", i), done_cnt - d0, 1);
            check_eq($sformatf("single %0d empty", i), int'(fifo_empty === 1'b1), 1);
            check_eq($sformatf("single %0d busy", i), int'(tx_busy === 1'b1), 0);
        end

        // Burst of three back-to-back writes
        d0 = done_cnt;
        for (int i = 3; i < 6; i++) push(vecs[i].data);
        wait_start(4 * BR, n);
        check_eq("burst start seen", int'(n < 4 * BR), 1);
        for (int i = 3; i < 6; i++) begin
            recv_frame($sformatf("burst %02h", vecs[i].data), vecs[i].frame, vecs[i].par);
            if (i < 5) check_gap($sformatf("burst %0d", i));
        end
        @(negedge clk_50MHz);
        check_eq("burst done count", done_cnt - d0, 3);
        check_eq("burst empty", int'(fifo_empty === 1'b1), 1);

        // Fill to overflow while a frame is on the line
        push(8'h5A);
        wait_start(BR + 2, n);
        check_eq("ovf start seen", int'(n <= BR), 1);
        fork
            recv_frame("ovf 5a", 10'b1010110100, 1'b0);
            begin
                check_eq("ovf empty after pop", int'(fifo_empty === 1'b1), 1);
                for (int i = 0; i < 17; i++) begin
                    wr_data = 8'(i);
                    wr_en   = 1'b1;
                    @(negedge clk_50MHz);
                    if (i == 14) check_eq("ovf full after 15", int'(fifo_full === 1'b1), 0);
                    if (i == 15) check_eq("ovf full after 16", int'(fifo_full === 1'b1), 1);
                end
                wr_en = 1'b0;
                check_eq("ovf full after drop", int'(fifo_full === 1'b1), 1);
            end
        join
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i);
            check_gap($sformatf("ovf %0d", i));
            recv_frame($sformatf("ovf %02h", b), {1'b1, b, 1'b0}, ^b);
        end
        @(negedge clk_50MHz);
        check_eq("ovf empty at end", int'(fifo_empty === 1'b1), 1);
        idle_watch("ovf dropped byte", 2 * BIT);

        // Write lands on the same edge as the pop of the last entry
        push(8'h3C);
        wait_start(BR + 2, n);
        fork
            recv_frame("sim 3c", 10'b1001111000, 1'b0);
            begin
                repeat (10) @(negedge clk_50MHz);
                push(8'h81);
            end
        join
        repeat (BR - 1) @(negedge clk_50MHz);
        check_eq("sim pre tx", int'(tx === 1'b1), 1);
        check_eq("sim pre empty", int'(fifo_empty === 1'b1), 0);
        wr_data = 8'h66;
        wr_en   = 1'b1;
        @(negedge clk_50MHz);
        wr_en   = 1'b0;
        check_eq("sim empty after push+pop", int'(fifo_empty === 1'b1), 0);
        check_eq("sim started", int'(tx === 1'b0), 1);
        recv_frame("sim 81", 10'b1100000010, 1'b0);
        check_gap("sim");
        recv_frame("sim 66", 10'b1011001100, 1'b0);
        @(negedge clk_50MHz);
        check_eq("sim empty at end", int'(fifo_empty === 1'b1), 1);

        // Reset asserted in the middle of the data bits
        push(8'hC3);
        wait_start(BR + 2, n);
        repeat (3 * BIT + BIT / 2) @(negedge clk_50MHz);
        check_eq("rstmid busy before", int'(tx_busy === 1'b1), 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check_eq("rstmid tx", int'(tx === 1'b1), 1);
        check_eq("rstmid empty", int'(fifo_empty === 1'b1), 1);
        check_eq("rstmid busy", int'(tx_busy === 1'b1), 0);
        @(negedge clk_50MHz);
        reset = 1'b1;
        idle_watch("rstmid after release", 3 * BIT);
        check_eq("rstmid no done", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
